// File: rtl/rename_dispatch.sv
// rename_dispatch: rename/dispatch stage of an out-of-order core.
// Takes a bundle of up to DISP_W uops (slot 0 oldest), assigns ROB tags and
// reservation-station slots, resolves each source operand, and writes the
// resolved entries to the RS in the same cycle. Source resolution order is:
// an older slot of the same bundle, then the CDB, then the busy table, then
// the register file. A per-register busy/tag table tracks in-flight
// producers.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   in_valid / in_ready          bundle handshake (in_valid packed from slot 0)
//   in_rs1/in_rs2/in_rd          per-slot physical register numbers
//   in_rd_valid, in_imm_valid    per-slot destination / immediate valid
//   in_imm, in_pc, in_op         per-slot immediate, PC, opcode
//   rf_rs*_addr / rf_rs*_data    combinational register-file read port
//   rob_tail, rob_free           ROB allocation state
//   rob_alloc_cnt                ROB entries consumed this cycle
//   rs_free                      free RS entries
//   rs_wr_en/rs_wr_addr/rs_data  RS write port
//                                (per slot {op,qj,qj_v,vj,qk,qk_v,vk,a,dest,pc,rob_tag})
//   cdb_valid/cdb_tag/cdb_data   result broadcast
//   retire_en/retire_tag         committed ROB tag
//   flush                        clears busy table, blocks dispatch
//   stall_cnt                    saturating count of stalled cycles
module rename_dispatch #(
    parameter int DISP_W = 2,
    parameter int PREG_N = 64,
    parameter int ROB_N  = 32,
    parameter int RS_N   = 16,
    parameter int PA_W   = $clog2(PREG_N),
    parameter int RA_W   = $clog2(ROB_N),
    parameter int SA_W   = $clog2(RS_N),
    parameter int RS_DW  = 8 + 2 * (RA_W + 1 + 32) + 32 + PA_W + 32 + RA_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DISP_W-1:0]        in_valid,
    output logic                     in_ready,
    input  logic [DISP_W*PA_W-1:0]   in_rs1,
    input  logic [DISP_W*PA_W-1:0]   in_rs2,
    input  logic [DISP_W*PA_W-1:0]   in_rd,
    input  logic [DISP_W-1:0]        in_rd_valid,
    input  logic [DISP_W-1:0]        in_imm_valid,
    input  logic [DISP_W*32-1:0]     in_imm,
    input  logic [DISP_W*32-1:0]     in_pc,
    input  logic [DISP_W*8-1:0]      in_op,
    output logic [DISP_W*PA_W-1:0]   rf_rs1_addr,
    output logic [DISP_W*PA_W-1:0]   rf_rs2_addr,
    input  logic [DISP_W*32-1:0]     rf_rs1_data,
    input  logic [DISP_W*32-1:0]     rf_rs2_data,
    input  logic [RA_W-1:0]          rob_tail,
    input  logic [RA_W:0]            rob_free,
    output logic [2:0]               rob_alloc_cnt,
    input  logic [SA_W:0]            rs_free,
    output logic [DISP_W-1:0]        rs_wr_en,
    output logic [DISP_W*SA_W-1:0]   rs_wr_addr,
    output logic [DISP_W*RS_DW-1:0]  rs_data,
    input  logic                     cdb_valid,
    input  logic [RA_W-1:0]          cdb_tag,
    input  logic [31:0]              cdb_data,
    input  logic                     retire_en,
    input  logic [RA_W-1:0]          retire_tag,
    input  logic                     flush,
    output logic [15:0]              stall_cnt
);

    logic [PREG_N-1:0] busy;
    logic [RA_W-1:0]   tags [PREG_N];
    logic [SA_W-1:0]   wr_ptr;
    logic [2:0]        n;
    logic              fire;
    logic [RA_W-1:0]   slot_tag [DISP_W];

    assign rf_rs1_addr = in_rs1;
    assign rf_rs2_addr = in_rs2;

    always_comb begin
        n = '0;
        for (int unsigned i = 0; i < DISP_W; i++) begin
            if (in_valid[i]) n = n + 3'd1;
            slot_tag[i] = rob_tail + RA_W'(i);
        end
    end

    assign in_ready = !rst && !flush
                      && (rob_free >= (RA_W + 1)'(n))
                      && (rs_free >= (SA_W + 1)'(n));
    assign fire          = in_ready && (n != '0);
    assign rob_alloc_cnt = fire ? n : '0;

    always_comb begin : dispatch
        logic [PA_W-1:0] src;
        logic [31:0]     rf;
        logic            older_hit;
        logic [RA_W-1:0] older_tag;
        logic [RA_W-1:0] q  [2];
        logic            qv [2];
        logic [31:0]     v  [2];
        logic [31:0]     a;
        logic [PA_W-1:0] dest;

        src       = '0;
        rf        = '0;
        older_hit = 1'b0;
        older_tag = '0;
        q         = '{default: '0};
        qv        = '{default: 1'b0};
        v         = '{default: '0};
        a         = '0;
        dest      = '0;
        rs_wr_en   = '0;
        rs_wr_addr = '0;
        rs_data    = '0;

        for (int unsigned i = 0; i < DISP_W; i++) begin
            for (int unsigned k = 0; k < 2; k++) begin
                src = (k == 0) ? in_rs1[i*PA_W +: PA_W] : in_rs2[i*PA_W +: PA_W];
                rf  = (k == 0) ? rf_rs1_data[i*32 +: 32] : rf_rs2_data[i*32 +: 32];
                // Scan older slots in order so the youngest match is kept.
                older_hit = 1'b0;
                older_tag = '0;
                for (int unsigned j = 0; j < DISP_W; j++) begin
                    if (j < i && in_rd_valid[j] && src != '0
                        && in_rd[j*PA_W +: PA_W] == src) begin
                        older_hit = 1'b1;
                        older_tag = slot_tag[j];
                    end
                end
                q[k]  = '0;
                qv[k] = 1'b0;
                v[k]  = '0;
                if (older_hit) begin
                    q[k]  = older_tag;
                    qv[k] = 1'b1;
                end else if (busy[src] && cdb_valid && tags[src] == cdb_tag) begin
                    v[k] = cdb_data;
                end else if (busy[src]) begin
                    q[k]  = tags[src];
                    qv[k] = 1'b1;
                end else if (src != '0) begin
                    v[k] = rf;
                end
            end
            a    = in_imm_valid[i] ? in_imm[i*32 +: 32] : '0;
            dest = in_rd_valid[i] ? in_rd[i*PA_W +: PA_W] : '0;
            rs_wr_en[i] = fire && in_valid[i];
            rs_wr_addr[i*SA_W +: SA_W] = wr_ptr + SA_W'(i);
            rs_data[i*RS_DW +: RS_DW] = {in_op[i*8 +: 8],
                                         q[0], qv[0], v[0],
                                         q[1], qv[1], v[1],
                                         a, dest, in_pc[i*32 +: 32], slot_tag[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy      <= '0;
            wr_ptr    <= '0;
            stall_cnt <= '0;
            for (int unsigned p = 0; p < PREG_N; p++) tags[p] <= '0;
        end else begin
            if (in_valid != '0 && !in_ready && stall_cnt != '1)
                stall_cnt <= stall_cnt + 16'd1;
            if (flush) begin
                busy <= '0;
            end else begin
                for (int unsigned p = 0; p < PREG_N; p++) begin
                    if (busy[p] && cdb_valid && tags[p] == cdb_tag) busy[p] <= 1'b0;
                    if (busy[p] && retire_en && tags[p] == retire_tag) busy[p] <= 1'b0;
                end
                // Sets come after clears and in slot order, so a set beats a
                // clear and the youngest writer of a register wins.
                if (fire) begin
                    for (int unsigned i = 0; i < DISP_W; i++) begin
                        if (in_valid[i] && in_rd_valid[i] && in_rd[i*PA_W +: PA_W] != '0) begin
                            busy[in_rd[i*PA_W +: PA_W]] <= 1'b1;
                            tags[in_rd[i*PA_W +: PA_W]] <= slot_tag[i];
                        end
                    end
                    wr_ptr <= wr_ptr + SA_W'(n);
                end
            end
        end
    end

endmodule

// File: doc/rename_dispatch.md
RENAME_DISPATCH -- requirements
Module: rename_dispatch

Interface
REQ-001 DISP_W, 2, uops per bundle (1..4); slot 0 is oldest.
REQ-002 PREG_N, 64, physical registers; PA_W = clog2(PREG_N).
REQ-003 ROB_N, 32, ROB entries (power of 2); RA_W = clog2(ROB_N).
REQ-004 RS_N, 16, reservation-station entries (power of 2); SA_W = clog2(RS_N).
REQ-005 clk  in  1  clock; all state updates on the rising edge.
REQ-006 rst  in  1  reset; synchronous, active-high.
REQ-007 in_valid  in  DISP_W  slot valid; packed from slot 0, no holes.
REQ-008 in_ready  out  1  bundle accepted this cycle.
REQ-009 in_rs1, in_rs2, in_rd  in  DISP_W*PA_W  per-slot physical sources and destination.
REQ-010 in_rd_valid, in_imm_valid  in  DISP_W  per-slot destination and immediate valid.
REQ-011 in_imm, in_pc  in  DISP_W*32  per-slot immediate and PC; in_op  in  DISP_W*8  opcode.
REQ-012 rf_rs1_addr, rf_rs2_addr  out  DISP_W*PA_W  register-file read addresses (= in_rs1/in_rs2).
REQ-013 rf_rs1_data, rf_rs2_data  in  DISP_W*32  combinational register-file read data.
REQ-014 rob_tail  in  RA_W  next free ROB tag; rob_free  in  RA_W+1  free ROB entries.
REQ-015 rob_alloc_cnt  out  3  ROB entries consumed this cycle.
REQ-016 rs_free  in  SA_W+1  free RS entries.
REQ-017 rs_wr_en  out  DISP_W; rs_wr_addr  out  DISP_W*SA_W; rs_data  out  per slot {op, qj, qj_v, vj, qk, qk_v, vk, a, dest, pc, rob_tag}.
REQ-018 cdb_valid  in  1; cdb_tag  in  RA_W; cdb_data  in  32  result broadcast.
REQ-019 retire_en  in  1; retire_tag  in  RA_W  committed ROB tag.
REQ-020 flush  in  1  pipeline flush.
REQ-021 stall_cnt  out  16  count of stalled cycles.

Function
REQ-022 n = popcount(in_valid); in_ready SHALL be 1 iff !rst && !flush && rob_free>=n && rs_free>=n; fire = in_ready && n!=0.
REQ-023 Slot i SHALL receive rob_tag = (rob_tail+i) mod ROB_N and rs_wr_addr = (wr_ptr+i) mod RS_N; rs_wr_en[i] = fire && in_valid[i].
REQ-024 rob_alloc_cnt SHALL be n when fire, else 0; wr_ptr SHALL advance by n on fire, wrapping mod RS_N.
REQ-025 Internal status table per physical register: busy bit + RA_W tag; register 0 is never busy and always reads as value 0.
REQ-026 Source resolution for slot i, register s, first match wins: (a) the youngest older slot j<i with in_rd_valid[j] and in_rd[j]==s!=0 -> q=tag_j, q_v=1, v=0; (b) busy[s] && cdb_valid && cdb_tag==tag[s] -> v=cdb_data, q_v=0; (c) busy[s] -> q=tag[s], q_v=1, v=0; (d) otherwise v=rf data, q=0, q_v=0.
REQ-027 a = in_imm_valid ? in_imm : 0; dest = in_rd_valid ? in_rd : 0.
REQ-028 All dispatch outputs are combinational (zero-cycle latency); table updates become visible the next cycle.
REQ-029 Table clear: on cdb_valid, and separately on retire_en, every busy entry whose tag equals the broadcast tag SHALL clear its busy bit.
REQ-030 Table set: on fire, each slot with in_rd_valid and rd!=0 SHALL set busy[rd] and tag[rd] = its rob_tag; if several slots share an rd, the youngest slot wins; a set overrides a clear in the same cycle.
REQ-031 flush SHALL clear all busy bits, block dispatch, and leave wr_ptr unchanged; flush has priority over fire.
REQ-032 stall_cnt SHALL increment when in_valid!=0 && !in_ready && !rst, and saturate at 0xFFFF.

Reset
REQ-033 In a cycle with rst=1: all busy bits 0, all tags 0, wr_ptr 0, stall_cnt 0.
REQ-034 While rst=1: in_ready=0, rs_wr_en=0, rob_alloc_cnt=0.

Verification
REQ-035 Bundle {slot0 rd=5, slot1 rs1=5}, rob_tail=7 -> slot1 qj=7, qj_v=1; slot0 tag 7, slot1 tag 8; next cycle tag[5]=8 if slot1 also writes rd=5.
REQ-036 busy[9] with tag=3, then cdb_valid with tag 3 and data 0xDEADBEEF in the same cycle as a source read of reg 9 -> vj=0xDEADBEEF, qj_v=0; next cycle busy[9]=0.
REQ-037 rob_free=1 with n=2 -> in_ready=0, rs_wr_en=0, stall_cnt increments by 1 per cycle; rob_free=2 -> fire, rob_alloc_cnt=2.
REQ-038 wr_ptr=15, RS_N=16, n=2 -> rs_wr_addr = {15, 0}; wr_ptr becomes 1.
REQ-039 Retire of tag 4 in the same cycle as a new fire setting reg 4's mapped register with tag 20 -> the entry holds busy=1, tag=20.
REQ-040 flush after 10 busy registers -> in_ready=0 that cycle; all sources resolve to rf data the next cycle.
